imem_responder: RTL

Instruction-memory responder for the Sodor core's front-end fetch port. It holds a small program store that is loaded before execution, then answers each `io_imem_req` with instruction data after a fixed latency. It stands in for the testbench-side program array in both simulation and BMC harnesses, with one instance per core copy.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_resp_pipe.sv | 44 ++++
 rtl/imem_responder.sv | 100 ++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory responder: fill word, FSM states, response record.
package imem_pkg;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DRAIN = 2'd2
    } imem_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } imem_resp_t;

endpackage

// File: rtl/imem_resp_pipe.sv
// LATENCY-deep response shift register; each stage keeps its last valid data so the
// output word holds steady between responses.
module imem_resp_pipe
    import imem_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter logic [31:0] FILL    = NOP_INSN
) (
    input  logic       clock,
    input  logic       reset,
    input  imem_resp_t i_resp,
    output imem_resp_t o_resp,
    output logic       o_empty
);

    imem_resp_t r_stage [LATENCY];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '{valid: 1'b0, data: FILL};
            end
        end else begin
            r_stage[0].valid <= i_resp.valid;
            if (i_resp.valid) r_stage[0].data <= i_resp.data;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i].valid <= r_stage[i-1].valid;
                if (r_stage[i-1].valid) r_stage[i].data <= r_stage[i-1].data;
            end
        end
    end

    assign o_resp = r_stage[LATENCY-1];

    // Empty means nothing remains behind the word currently presented at the output,
    // so DRAIN can leave on the same edge that retires the final response.
    always_comb begin
        o_empty = 1'b1;
        for (int i = 0; i < LATENCY - 1; i++) begin
            if (r_stage[i].valid) o_empty = 1'b0;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: program store loaded in LOAD, fetches served in SERVE.
// Define IMEM_RESP_WRAP_EN to wrap addresses modulo DEPTH instead of flagging them.
module imem_responder #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned LATENCY  = 1,
    parameter logic [31:0] NOP_INSN = imem_pkg::NOP_INSN
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data,
    input  logic                     run,
    input  logic                     io_imem_req_valid,
    input  logic [31:0]              io_imem_req_bits_addr,
    output logic                     io_imem_req_ready,
    output logic                     io_imem_resp_valid,
    output logic [31:0]              io_imem_resp_bits_data,
    output logic [15:0]              fetch_count,
    output logic                     oob
);
    import imem_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    imem_state_e      r_state, w_next;
    logic [31:0]      r_store [DEPTH];
    logic [15:0]      r_count;
    logic             r_oob;
    logic             w_accept, w_bad, w_empty;
    logic [AW-1:0]    w_idx;
    imem_resp_t       w_pipe_in, w_pipe_out;

    assign load_ready        = (r_state == LOAD)  && reset;
    assign io_imem_req_ready = (r_state == SERVE) && reset;
    assign w_accept          = io_imem_req_valid && io_imem_req_ready;
    assign w_idx             = io_imem_req_bits_addr[AW+1:2];

`ifdef IMEM_RESP_WRAP_EN
    logic w_unused_addr;
    assign w_unused_addr = ^{io_imem_req_bits_addr[31:AW+2], io_imem_req_bits_addr[1:0]};
    assign w_bad         = 1'b0;
`else
    assign w_bad = (io_imem_req_bits_addr[31:AW+2] != '0) || (io_imem_req_bits_addr[1:0] != 2'b00);
`endif

    assign w_pipe_in.valid = w_accept;
    assign w_pipe_in.data  = w_bad ? NOP_INSN : r_store[w_idx];

    imem_resp_pipe #(
        .LATENCY (LATENCY),
        .FILL    (NOP_INSN)
    ) u_pipe (
        .clock   (clock),
        .reset   (reset),
        .i_resp  (w_pipe_in),
        .o_resp  (w_pipe_out),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            LOAD:    if (run)     w_next = SERVE;
            SERVE:   if (!run)    w_next = DRAIN;
            DRAIN:   if (w_empty) w_next = LOAD;
            default:              w_next = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= LOAD;
        else        r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_store[i] <= NOP_INSN;
        end else if (load_ready && load_valid) begin
            r_store[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
            r_oob   <= 1'b0;
        end else begin
            if (w_pipe_out.valid && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
            if (w_accept && w_bad) r_oob <= 1'b1;
        end
    end

    assign io_imem_resp_valid     = w_pipe_out.valid;
    assign io_imem_resp_bits_data = w_pipe_out.data;
    assign fetch_count            = r_count;
    assign oob                    = r_oob;

endmodule
